// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC display path: RTC register map, BCD field
// positions inside the time/date words, and the poll FSM state type.
package rtc_pkg;

    typedef enum logic [7:0] {
        CTRL       = 8'h00,
        STATUS     = 8'h04,
        SET_DATE   = 8'h08,
        SET_TIME   = 8'h0C,
        ALARM_DATE = 8'h10,
        CUR_DATE   = 8'h14,
        CUR_TIME   = 8'h18,
        ALARM_TIME = 8'h1C,
        IRQ_EN     = 8'h20,
        IRQ_STATUS = 8'h24,
        PRESCALE   = 8'h28
    } rtc_reg_t;

    // Time word is 00_HH_MM_SS, date word is YYYY_MM_DD.
    localparam int unsigned TIME_W        = 24;
    localparam int unsigned TIME_MIN_LSB  = 8;
    localparam int unsigned TIME_HOUR_LSB = 16;
    localparam int unsigned DATE_MON_LSB  = 8;
    localparam int unsigned DATE_YEAR_LSB = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_TIME,
        GAP1,
        RD_DATE,
        COMMIT
    } poll_state_t;

    function automatic logic [3:0] bcd_nibble(input logic [31:0] word, input logic [2:0] idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/rtc_bcd7seg.sv
// BCD nibble to seven-segment decoder; non-decimal nibbles and blanked digits
// light nothing. Output is active-high {g,f,e,d,c,b,a}.
module rtc_bcd7seg (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = '0;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = 7'h3F;
                4'd1:    seg = 7'h06;
                4'd2:    seg = 7'h5B;
                4'd3:    seg = 7'h4F;
                4'd4:    seg = 7'h66;
                4'd5:    seg = 7'h6D;
                4'd6:    seg = 7'h7D;
                4'd7:    seg = 7'h07;
                4'd8:    seg = 7'h7F;
                4'd9:    seg = 7'h6F;
                default: seg = '0;
            endcase
        end
    end

endmodule

// File: rtl/rtc_seg_display.sv
// Polls the RTC current-time/current-date registers over the mem_* bus and
// scans the latched BCD snapshot onto an 8-digit multiplexed 7-segment display.
module rtc_seg_display
    import rtc_pkg::*;
#(
    parameter logic [31:0] RTC_BASE       = 32'h8100_9000,
    parameter logic [31:0] POLL_CYCLES    = 32'd1_000_000,
    parameter logic [31:0] SCAN_CYCLES    = 32'd100_000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd64,
    parameter logic        SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        show_date,
    input  logic        rtc_irq,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        bus_err
);

    poll_state_t state, state_next;

    logic              irq_d;
    logic              irq_pulse;
    logic              pending;
    logic              enter_rd_time;
    logic              timeout_hit;
    logic              abort;
    logic [31:0]       poll_cnt;
    logic [15:0]       timeout_cnt;
    logic [TIME_W-1:0] time_shadow, time_disp;
    logic [31:0]       date_shadow, date_disp;

    logic [31:0]       scan_cnt;
    logic [2:0]        digit_idx;
    logic              mode_date;
    logic              scan_en;
    logic [3:0]        nibble;
    logic              blank;
    logic              dp_on;
    logic [6:0]        seg_raw;

    assign mem_instr = 1'b0;
    assign mem_wdata = '0;
    assign mem_wstrb = '0;

    assign irq_pulse   = rtc_irq & ~irq_d;
    assign timeout_hit = (timeout_cnt == TIMEOUT_CYCLES - 16'd1);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pending || poll_cnt >= POLL_CYCLES - 32'd1) state_next = RD_TIME;
            RD_TIME: if (mem_ready) state_next = GAP1;
                     else if (timeout_hit) state_next = IDLE;
            GAP1:    state_next = RD_DATE;
            RD_DATE: if (mem_ready) state_next = COMMIT;
                     else if (timeout_hit) state_next = IDLE;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_rd_time = (state == IDLE) && (state_next == RD_TIME);
    assign abort = (state == RD_TIME || state == RD_DATE) && !mem_ready && timeout_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mem_valid   <= 1'b0;
            mem_addr    <= '0;
            bus_err     <= 1'b0;
            irq_d       <= 1'b0;
            pending     <= 1'b1;
            poll_cnt    <= '0;
            timeout_cnt <= '0;
            time_shadow <= '0;
            date_shadow <= '0;
            time_disp   <= '0;
            date_disp   <= '0;
        end else begin
            state   <= state_next;
            irq_d   <= rtc_irq;
            // An edge coinciding with poll entry is absorbed by that poll.
            pending  <= (pending | irq_pulse) & ~enter_rd_time;
            poll_cnt <= enter_rd_time ? '0 : poll_cnt + 32'd1;

            if ((state_next == RD_TIME || state_next == RD_DATE) && state_next == state)
                timeout_cnt <= timeout_cnt + 16'd1;
            else
                timeout_cnt <= '0;

            // Registered from next state so valid falls right after ready is seen.
            mem_valid <= (state_next == RD_TIME) || (state_next == RD_DATE);
            if (state_next == RD_TIME)
                mem_addr <= RTC_BASE + {24'h0, CUR_TIME};
            else if (state_next == RD_DATE)
                mem_addr <= RTC_BASE + {24'h0, CUR_DATE};

            if (state == RD_TIME && mem_ready) time_shadow <= mem_rdata[TIME_W-1:0];
            if (state == RD_DATE && mem_ready) date_shadow <= mem_rdata;
            if (state == COMMIT) begin
                time_disp <= time_shadow;
                date_disp <= date_shadow;
            end
            if (abort) bus_err <= 1'b1;
        end
    end

    always_comb begin
        nibble = '0;
        blank  = 1'b0;
        if (mode_date)
            nibble = bcd_nibble(date_disp, digit_idx);
        else if (digit_idx >= 3'd6)
            blank = 1'b1;
        else
            nibble = bcd_nibble({8'h00, time_disp}, digit_idx);
    end

    always_comb begin
        dp_on = 1'b0;
        if (mode_date)
            dp_on = (digit_idx == 3'(DATE_YEAR_LSB / 4)) || (digit_idx == 3'(DATE_MON_LSB / 4));
        else
            dp_on = (digit_idx == 3'(TIME_HOUR_LSB / 4)) || (digit_idx == 3'(TIME_MIN_LSB / 4));
    end

    rtc_bcd7seg u_dec (
        .nibble (nibble),
        .blank  (blank),
        .seg    (seg_raw)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            mode_date <= 1'b0;
            scan_en   <= 1'b0;
            an        <= {8{SEG_ACTIVE_LOW}};
            seg       <= {7{SEG_ACTIVE_LOW}};
            dp        <= SEG_ACTIVE_LOW;
        end else begin
            scan_en <= 1'b1;
            if (scan_cnt == SCAN_CYCLES - 32'd1) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
                mode_date <= show_date;
            end else begin
                scan_cnt <= scan_cnt + 32'd1;
            end
            // Outputs stay dark for the first cycle out of reset.
            if (scan_en) begin
                an  <= (8'd1 << digit_idx) ^ {8{SEG_ACTIVE_LOW}};
                seg <= seg_raw ^ {7{SEG_ACTIVE_LOW}};
                dp  <= dp_on ^ SEG_ACTIVE_LOW;
            end
        end
    end

endmodule

// File: tb/tb_rtc_seg_display.sv
// Scoreboard bench for rtc_seg_display: an RTC bus model answers reads, and
// monitors compare bus requests and scanned digits against queued expectations.
`timescale 1ns/1ps
module tb_rtc_seg_display;

    localparam logic [31:0] BASE = 32'h8100_9000;

    logic        clk = 1'b0;
    logic        reset, show_date, rtc_irq;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [6:0]  seg;
    logic        dp, bus_err;
    logic [7:0]  an;

    always #5 clk = ~clk;

    rtc_seg_display #(
        .RTC_BASE       (BASE),
        .POLL_CYCLES    (32'd1000),
        .SCAN_CYCLES    (32'd4),
        .TIMEOUT_CYCLES (16'd64),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .show_date (show_date),
        .rtc_irq   (rtc_irq),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .bus_err   (bus_err)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RTC model: ready in the second cycle of each request.
    logic        rtc_alive;
    logic [31:0] time_val, date_val;
    int unsigned wait_cnt = 0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
    end

    always @(negedge clk) begin
        if (mem_valid && rtc_alive) begin
            if (wait_cnt == 1) begin
                mem_ready = 1'b1;
                if (mem_addr == BASE + 32'h18)      mem_rdata = time_val;
                else if (mem_addr == BASE + 32'h14) mem_rdata = date_val;
                else                                mem_rdata = 32'hDEAD_BEEF;
            end else begin
                mem_ready = 1'b0;
            end
            wait_cnt++;
        end else begin
            mem_ready = 1'b0;
            mem_rdata = '0;
            wait_cnt  = 0;
        end
    end

    typedef struct { logic [31:0] addr; bit aborted; } bus_exp_t;
    typedef struct { int unsigned idx; logic [6:0] seg; logic dp; } disp_exp_t;

    bus_exp_t    bus_q[$];
    disp_exp_t   disp_q[$];
    bus_exp_t    cur;
    bit          txn_open = 0;
    bit          bus_mon_en = 1;
    int unsigned dur = 0;
    logic        prev_valid = 1'b0;

    // Bus monitor: address checked on request start, length and error on its end.
    always @(negedge clk) begin
        if (bus_mon_en) begin
            if (mem_valid && !prev_valid) begin
                dur = 1;
                if (bus_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    txn_open = 0;
                    $display("FAIL bus_unexpected: request to %h, expected none", mem_addr);
                end else begin
                    cur = bus_q.pop_front();
                    txn_open = 1;
                    check("bus_addr", mem_addr, cur.addr);
                end
            end else if (mem_valid) begin
                dur++;
            end else if (prev_valid && txn_open) begin
                check("bus_len", dur, cur.aborted ? 32'd64 : 32'd2);
                if (cur.aborted) check("bus_err_on_timeout", {31'b0, bus_err}, 32'd1);
                txn_open = 0;
            end
        end
        prev_valid = mem_valid;
    end

    // Display monitor: each newly activated digit is compared against the head entry.
    logic [7:0] an_prev = 8'hFF;
    always @(negedge clk) begin
        int unsigned idx;
        bit found;
        logic [7:0] onehot;
        if (an !== an_prev) begin
            an_prev = an;
            found = 0;
            idx = 0;
            for (int i = 0; i < 8; i++) begin
                onehot = 8'd1 << i;
                if (an === ~onehot) begin
                    found = 1;
                    idx = i;
                end
            end
            if (found && disp_q.size() > 0 && disp_q[0].idx == idx) begin
                check($sformatf("seg_digit%0d", idx), {25'b0, seg}, {25'b0, disp_q[0].seg});
                check($sformatf("dp_digit%0d", idx), {31'b0, dp}, {31'b0, disp_q[0].dp});
                void'(disp_q.pop_front());
            end
        end
    end

    // Active-low segment codes per digit index 0..7; dp is lit at digits 2 and 4.
    logic [6:0] frame_time [8] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F};
    logic [6:0] frame_date [8] = '{7'h79, 7'h40, 7'h79, 7'h40, 7'h02, 7'h24, 7'h40, 7'h24};
    logic [6:0] frame_hexa [8] = '{7'h02, 7'h12, 7'h19, 7'h7F, 7'h24, 7'h79, 7'h7F, 7'h7F};
    localparam logic [7:0] DP_MASK = 8'b1110_1011;

    task automatic push_frame(input logic [6:0] segs [8]);
        disp_exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.idx = i;
            e.seg = segs[i];
            e.dp  = DP_MASK[i];
            disp_q.push_back(e);
        end
    endtask

    task automatic push_poll(input bit aborted_time);
        bus_exp_t e;
        e.addr = BASE + 32'h18;
        e.aborted = aborted_time;
        bus_q.push_back(e);
        if (!aborted_time) begin
            e.addr = BASE + 32'h14;
            e.aborted = 0;
            bus_q.push_back(e);
        end
    endtask

    task automatic wait_bus_drain(input string name, input int unsigned budget);
        int unsigned n = 0;
        while ((bus_q.size() != 0 || txn_open) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_bus_outstanding"}, bus_q.size() + int'(txn_open), 32'd0);
    endtask

    task automatic wait_disp_drain(input string name, input int unsigned budget);
        int unsigned n = 0;
        while (disp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_digits_outstanding"}, disp_q.size(), 32'd0);
    endtask

    task automatic wait_rise(input string name, input int unsigned budget, output int unsigned t);
        logic prev;
        int unsigned n = 0;
        bit found = 0;
        prev = mem_valid;
        while (!found && n < budget) begin
            @(negedge clk);
            n++;
            if (mem_valid && !prev) found = 1;
            prev = mem_valid;
        end
        t = cyc;
        check({name, "_request_seen"}, {31'b0, found}, 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, t_irq, t_per, t_rd, t_extra, t_to, t_rec, t0, t_end;
        logic [7:0] prev_an, onehot;
        bit found;

        reset = 1'b1;
        show_date = 1'b0;
        rtc_irq = 1'b0;
        rtc_alive = 1'b1;
        time_val = 32'h0012_3456;
        date_val = 32'h2026_0101;
        repeat (4) @(negedge clk);

        check("reset_mem_valid", {31'b0, mem_valid}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_bus_err", {31'b0, bus_err}, 32'd0);
        check("reset_an", {24'b0, an}, 32'hFF);
        check("reset_seg", {25'b0, seg}, 32'h7F);
        check("reset_dp", {31'b0, dp}, 32'd1);
        check("tie_offs", {mem_wdata[30:0] | {27'b0, mem_wstrb}, mem_instr}, 32'd0);

        push_poll(0);
        reset = 1'b0;
        @(negedge clk);
        check("an_dark_first_cycle", {24'b0, an}, 32'hFF);
        @(negedge clk);
        check("an_digit0_after_reset", {24'b0, an}, 32'hFE);
        check("seg_zero_before_commit", {25'b0, seg}, 32'h40);

        wait_bus_drain("first_poll", 40);
        repeat (10) @(negedge clk);

        push_poll(0);
        rtc_irq = 1'b1;
        n = 0;
        while (!mem_valid && n < 3) begin
            @(negedge clk);
            n++;
        end
        check("irq_poll_within_3", {31'b0, mem_valid}, 32'd1);
        t_irq = cyc;
        rtc_irq = 1'b0;
        wait_bus_drain("irq_poll", 20);
        repeat (4) @(negedge clk);

        push_frame(frame_time);
        wait_disp_drain("time_view", 80);
        show_date = 1'b1;
        repeat (40) @(negedge clk);
        push_frame(frame_date);
        wait_disp_drain("date_view", 80);
        show_date = 1'b0;
        repeat (40) @(negedge clk);

        push_poll(0);
        wait_rise("periodic", 1100, t_per);
        check("poll_period_after_irq", t_per - t_irq, 32'd1000);
        wait_rise("rd_date", 10, t_rd);
        rtc_irq = 1'b1;
        push_poll(0);
        wait_rise("extra_poll", 12, t_extra);
        rtc_irq = 1'b0;
        wait_bus_drain("extra_poll", 20);

        rtc_alive = 1'b0;
        time_val = 32'h0012_A456;
        push_poll(1);
        wait_rise("timeout_poll", 1100, t_to);
        check("idle_until_period", t_to - t_extra, 32'd1000);
        wait_bus_drain("timeout_poll", 100);
        check("valid_low_after_timeout", {31'b0, mem_valid}, 32'd0);
        push_frame(frame_time);
        wait_disp_drain("kept_after_timeout", 80);

        rtc_alive = 1'b1;
        push_poll(0);
        wait_rise("poll_after_timeout", 1100, t_rec);
        check("period_after_timeout", t_rec - t_to, 32'd1000);
        wait_bus_drain("poll_after_timeout", 20);
        repeat (4) @(negedge clk);
        push_frame(frame_hexa);
        wait_disp_drain("non_bcd_blank", 80);
        check("bus_err_sticky", {31'b0, bus_err}, 32'd1);

        prev_an = an;
        found = 0;
        n = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            if (an === 8'hFE && prev_an !== 8'hFE) found = 1;
            prev_an = an;
        end
        check("scan_digit0_entry", {31'b0, found}, 32'd1);
        t0 = cyc;
        for (int k = 1; k <= 8; k++) begin
            n = 0;
            prev_an = an;
            while (an === prev_an && n < 10) begin
                @(negedge clk);
                n++;
            end
            onehot = 8'd1 << (k % 8);
            check($sformatf("scan_an_step%0d", k), {24'b0, an}, {24'b0, ~onehot});
            check($sformatf("scan_dwell_step%0d", k), n, 32'd4);
        end
        check("scan_frame_period", cyc - t0, 32'd32);

        bus_mon_en = 0;
        wait_rise("final_poll", 1100, t_end);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_txn_valid", {31'b0, mem_valid}, 32'd0);
        check("reset_clears_bus_err", {31'b0, bus_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
